pci_bus_master: RTL and testbench

PCI_BUS_MASTER -- requirements
Module: pci_bus_master

---
 rtl/pci_bus_master.sv | 121 ++++++++++++
 tb/tb_pci_bus_master.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pci_bus_master.sv
// Single-agent PCI bus master: requests the bus, then runs one address cycle
// and a burst of 1..16 data beats. It aborts if no grant arrives within REQ_TIMEOUT cycles.
module pci_bus_master #(
  parameter int unsigned REQ_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       xfer_valid,
  input  logic [3:0] xfer_len,
  output logic       xfer_ready,
  output logic       xfer_done,
  output logic       xfer_err,
  output logic       data_beat,
  output logic [3:0] beat_idx,
  output logic       pci_req,
  input  logic       pci_grnt,
  output logic       pci_frame
);

  typedef enum logic [2:0] {StIdle, StReq, StAddr, StData, StTurn} state_e;

  localparam logic [7:0] WaitLast = 8'(REQ_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] len_q, len_d;
  logic [7:0] wait_q, wait_d;
  logic       req_q, req_d;
  logic       frame_q, frame_d;
  logic       beat_q, beat_d;
  logic [3:0] idx_q, idx_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  // The *_d values are the output levels for the cycle after the edge.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wait_d  = wait_q;
    req_d   = 1'b0;
    frame_d = 1'b0;
    beat_d  = 1'b0;
    idx_d   = 4'd0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer_valid) begin
          len_d   = xfer_len;
          wait_d  = 8'd0;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        // A grant sampled on the timeout edge takes priority over the abort.
        if (pci_grnt) begin
          wait_d  = 8'd0;
          frame_d = 1'b1;
          state_d = StAddr;
        end else if (wait_q == WaitLast) begin
          wait_d  = 8'd0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 8'd1;
          req_d  = 1'b1;
        end
      end
      StAddr: begin
        frame_d = 1'b1;
        beat_d  = 1'b1;
        state_d = StData;
      end
      StData: begin
        if (idx_q == len_q) begin
          done_d  = 1'b1;
          state_d = StTurn;
        end else begin
          frame_d = 1'b1;
          beat_d  = 1'b1;
          idx_d   = idx_q + 4'd1;
        end
      end
      StTurn: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= 4'd0;
      wait_q  <= 8'd0;
      req_q   <= 1'b0;
      frame_q <= 1'b0;
      beat_q  <= 1'b0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      frame_q <= frame_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign xfer_ready = (state_q == StIdle);
  assign xfer_done  = done_q;
  assign xfer_err   = err_q;
  assign data_beat  = beat_q;
  assign beat_idx   = idx_q;
  assign pci_req    = req_q;
  assign pci_frame  = frame_q;

endmodule

// File: tb/tb_pci_bus_master.sv
// Randomized bench for pci_bus_master: each transfer's expected waveform is
// derived from its grant cycle and length as a timeline, then checked cycle by cycle.
module tb_pci_bus_master;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       xfer_valid;
  logic [3:0] xfer_len;
  logic       xfer_ready;
  logic       xfer_done;
  logic       xfer_err;
  logic       data_beat;
  logic [3:0] beat_idx;
  logic       pci_req;
  logic       pci_grnt;
  logic       pci_frame;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pci_bus_master #(.REQ_TIMEOUT(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xfer_valid (xfer_valid),
    .xfer_len   (xfer_len),
    .xfer_ready (xfer_ready),
    .xfer_done  (xfer_done),
    .xfer_err   (xfer_err),
    .data_beat  (data_beat),
    .beat_idx   (beat_idx),
    .pci_req    (pci_req),
    .pci_grnt   (pci_grnt),
    .pci_frame  (pci_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string where, input bit req, input bit frame, input bit beat,
                            input int idx, input bit done, input bit err, input bit ready);
    check({where, " pci_req"}, pci_req, req);
    check({where, " pci_frame"}, pci_frame, frame);
    check({where, " data_beat"}, data_beat, beat);
    check({where, " beat_idx"}, beat_idx, idx);
    check({where, " xfer_done"}, xfer_done, done);
    check({where, " xfer_err"}, xfer_err, err);
    check({where, " xfer_ready"}, xfer_ready, ready);
  endtask

  task automatic idle_cycles(input int n);
    xfer_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outs($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 1);
      pci_grnt = 1'($urandom);
    end
  endtask

  // w = REQ cycles with grant low before the granted cycle; w >= T means no grant.
  // rst_at >= 0 pulses reset at that cycle offset after acceptance.
  task automatic run_xfer(input int len, input int w, input int rst_at);
    bit timeout;
    int g, last;
    bit e_req, e_frame, e_beat, e_done, e_err, e_ready;
    int e_idx;
    string where;
    timeout = (w > T - 1);
    g = w + 1;
    last = timeout ? T : g + len + 3;
    xfer_valid = 1'b1;
    xfer_len = 4'(len);
    pci_grnt = 1'($urandom);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      where = $sformatf("len%0d w%0d k%0d", len, w, k);
      if (timeout) begin
        e_req = (k < T); e_frame = 0; e_beat = 0; e_idx = 0;
        e_done = 0; e_err = (k == T); e_ready = (k >= T);
      end else begin
        e_req   = (k < g);
        e_frame = (k >= g) && (k < g + len + 2);
        e_beat  = (k >= g + 1) && (k <= g + 1 + len);
        e_idx   = e_beat ? k - g - 1 : 0;
        e_done  = (k == g + len + 2);
        e_err   = 0;
        e_ready = (k >= g + len + 3);
      end
      check_outs(where, e_req, e_frame, e_beat, e_idx, e_done, e_err, e_ready);
      check({where, " req&frame"}, pci_req & pci_frame, 0);
      if (k == rst_at) begin
        rst_n = 1'b0;
        xfer_valid = 1'b0;
        #1;
        check_outs({where, " in reset"}, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check_outs({where, " held reset"}, 0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        return;
      end
      // Inputs in busy cycles are noise; only the IDLE cycle at 'last' must be quiet.
      xfer_valid = (k < last) ? 1'($urandom) : 1'b0;
      xfer_len = 4'($urandom);
      if (timeout) pci_grnt = (k < T) ? 1'b0 : 1'($urandom);
      else pci_grnt = (k < w) ? 1'b0 : (k == w) ? 1'b1 : 1'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, w;
    rst_n = 1'b0;
    xfer_valid = 1'b0;
    xfer_len = 4'd0;
    pci_grnt = 1'b0;
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    check_outs("reset held", 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    idle_cycles(2);

    run_xfer(0, 1, -1);          // single beat, grant one cycle late
    idle_cycles(2);
    run_xfer(15, 0, -1);         // longest burst, immediate grant
    idle_cycles(1);
    run_xfer(3, T, -1);          // never granted: timeout
    idle_cycles(2);
    run_xfer(2, T - 1, -1);      // grant on the timeout edge
    idle_cycles(1);
    run_xfer(5, 0, -1);          // grant noise and valid toggling mid-burst
    idle_cycles(1);
    run_xfer(5, 0, 4);           // reset at beat 3 (ADDR at k=1, DATA from k=2)
    idle_cycles(2);
    run_xfer(4, 2, -1);          // normal transfer after reset
    idle_cycles(1);

    for (int i = 0; i < 40; i++) begin
      len = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) w = int'($urandom_range(T - 4, T + 4));
      else w = int'($urandom_range(0, 8));
      run_xfer(len, w, -1);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
